// File: rtl/pps_meter_pkg.sv
// Shared types for the 1PPS phase meter.
//   meter_state_e : measurement FSM states
//   AVG_LOG2_DEF  : default log2 of samples per average
//   SAMPLE_N      : default samples per average
//   sample_n()    : samples per average for a given log2
package pps_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLoc,
    StWaitGps
  } meter_state_e;

  localparam int unsigned AVG_LOG2_DEF = 3;
  localparam int unsigned SAMPLE_N     = 1 << AVG_LOG2_DEF;

  function automatic int unsigned sample_n(input int unsigned log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Brings an asynchronous 1PPS level into the CLK_Sys domain and turns its rising edge
// into a single-cycle pulse. Latency is fixed, so two instances keep relative timing.
//   CLK_Sys  : system clock
//   CLK_Rst  : asynchronous active-low reset
//   i_pps    : asynchronous PPS level
//   o_pulse  : one-cycle pulse per rising edge
module pps_edge_sync
  import pps_meter_pkg::*;
(
  input  logic CLK_Sys,
  input  logic CLK_Rst,
  input  logic i_pps,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_dly;

  always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
    if (!CLK_Rst) begin
      r_sync <= 2'b00;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pps};
      r_dly  <= r_sync[1];
    end
  end

  assign o_pulse = r_sync[1] & ~r_dly;

endmodule

// File: rtl/pps_phase_meter.sv
// Measures signed GPS-vs-local 1PPS phase in CLK_Sys cycles, averages 2^AVG_LOG2 samples,
// tracks GPS presence with a timeout and flags measurements that exceed the window.
//   CLK_Sys / CLK_Rst           : clock, asynchronous active-low reset
//   i_1PPS_GPS / i_1PPS_Local   : asynchronous PPS inputs
//   o_GPS_Exist                 : GPS 1PPS present
//   o_phase_valid / o_phase_val : strobe + signed phase (positive: local lags GPS)
//   o_avg_valid / o_phase_avg   : strobe + signed floor average
//   o_overflow                  : strobe, window expired and sample discarded
module pps_phase_meter
  import pps_meter_pkg::*;
#(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
  parameter int unsigned MAX_WIN  = 5_000_000,
  parameter int unsigned TIMEOUT  = 12_000_000
) (
  input  logic             CLK_Sys,
  input  logic             CLK_Rst,
  input  logic             i_1PPS_GPS,
  input  logic             i_1PPS_Local,
  output logic             o_GPS_Exist,
  output logic             o_phase_valid,
  output logic [CNT_W:0]   o_phase_val,
  output logic             o_avg_valid,
  output logic [CNT_W:0]   o_phase_avg,
  output logic             o_overflow
);

  localparam int unsigned VAL_W   = CNT_W + 1;
  localparam int unsigned ACC_W   = CNT_W + 1 + AVG_LOG2;
  localparam int unsigned NS_W    = AVG_LOG2 + 1;
  localparam int unsigned EX_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned SampleN = sample_n(AVG_LOG2);

  localparam logic [CNT_W-1:0] MaxWin  = CNT_W'(MAX_WIN);
  localparam logic [EX_W-1:0]  Timeout = EX_W'(TIMEOUT);
  localparam logic [NS_W-1:0]  NFull   = NS_W'(SampleN);

  logic w_gps_p, w_loc_p, w_loc_ok, w_exist_drop;

  pps_edge_sync u_sync_gps (
    .CLK_Sys (CLK_Sys),
    .CLK_Rst (CLK_Rst),
    .i_pps   (i_1PPS_GPS),
    .o_pulse (w_gps_p)
  );

  pps_edge_sync u_sync_loc (
    .CLK_Sys (CLK_Sys),
    .CLK_Rst (CLK_Rst),
    .i_pps   (i_1PPS_Local),
    .o_pulse (w_loc_p)
  );

  // GPS presence timer
  logic [EX_W-1:0] r_exist_cnt, w_exist_cnt_d;
  logic            r_gps_exist, w_gps_exist_d;

  always_comb begin
    w_exist_cnt_d = r_exist_cnt;
    w_gps_exist_d = r_gps_exist;
    if (w_gps_p) begin
      w_exist_cnt_d = '0;
      w_gps_exist_d = 1'b1;
    end else begin
      if (r_exist_cnt != Timeout) w_exist_cnt_d = r_exist_cnt + EX_W'(1);
      if (w_exist_cnt_d == Timeout) w_gps_exist_d = 1'b0;
    end
  end

  assign w_exist_drop = r_gps_exist & ~w_gps_exist_d;
  // Without GPS there is nothing to measure against, so a lone local edge is ignored.
  assign w_loc_ok     = w_loc_p & r_gps_exist;

  // Measurement FSM
  meter_state_e     r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W:0]   r_phase_val, w_phase_val_d;
  logic             r_phase_valid, w_phase_valid_d;
  logic             r_overflow, w_overflow_d;

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_phase_val_d   = r_phase_val;
    w_phase_valid_d = 1'b0;
    w_overflow_d    = 1'b0;
    if (w_exist_drop) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_gps_p && w_loc_ok) begin
            w_phase_val_d   = '0;
            w_phase_valid_d = 1'b1;
          end else if (w_gps_p) begin
            w_state_d = StWaitLoc;
            w_cnt_d   = CNT_W'(1);
          end else if (w_loc_ok) begin
            w_state_d = StWaitGps;
            w_cnt_d   = CNT_W'(1);
          end
        end
        StWaitLoc, StWaitGps: begin
          // Closing pulse beats both a restart and the window limit.
          if ((r_state == StWaitLoc) ? w_loc_p : w_gps_p) begin
            w_phase_val_d   = (r_state == StWaitLoc) ? {1'b0, r_cnt} : -{1'b0, r_cnt};
            w_phase_valid_d = 1'b1;
            w_state_d       = StIdle;
            w_cnt_d         = '0;
          end else if ((r_state == StWaitLoc) ? w_gps_p : w_loc_p) begin
            w_cnt_d = CNT_W'(1);
          end else if (r_cnt == MaxWin) begin
            w_overflow_d = 1'b1;
            w_state_d    = StIdle;
            w_cnt_d      = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Averager
  logic signed [ACC_W-1:0] r_acc, w_acc_d;
  logic [NS_W-1:0]         r_nsamp, w_nsamp_d;
  logic [CNT_W:0]          r_phase_avg, w_phase_avg_d;
  logic                    r_avg_valid, w_avg_valid_d;

  always_comb begin
    w_acc_d       = r_acc;
    w_nsamp_d     = r_nsamp;
    w_phase_avg_d = r_phase_avg;
    w_avg_valid_d = 1'b0;
    if (w_exist_drop) begin
      w_acc_d   = '0;
      w_nsamp_d = '0;
    end else begin
      if (r_nsamp == NFull) begin
        w_phase_avg_d = VAL_W'(r_acc >>> AVG_LOG2);
        w_avg_valid_d = 1'b1;
        w_acc_d       = '0;
        w_nsamp_d     = '0;
      end
      if (r_phase_valid) begin
        w_acc_d   = w_acc_d + ACC_W'($signed(r_phase_val));
        w_nsamp_d = w_nsamp_d + NS_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
    if (!CLK_Rst) begin
      r_exist_cnt   <= '0;
      r_gps_exist   <= 1'b0;
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_phase_val   <= '0;
      r_phase_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_acc         <= '0;
      r_nsamp       <= '0;
      r_phase_avg   <= '0;
      r_avg_valid   <= 1'b0;
    end else begin
      r_exist_cnt   <= w_exist_cnt_d;
      r_gps_exist   <= w_gps_exist_d;
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_phase_val   <= w_phase_val_d;
      r_phase_valid <= w_phase_valid_d;
      r_overflow    <= w_overflow_d;
      r_acc         <= w_acc_d;
      r_nsamp       <= w_nsamp_d;
      r_phase_avg   <= w_phase_avg_d;
      r_avg_valid   <= w_avg_valid_d;
    end
  end

  assign o_GPS_Exist   = r_gps_exist;
  assign o_phase_valid = r_phase_valid;
  assign o_phase_val   = r_phase_val;
  assign o_avg_valid   = r_avg_valid;
  assign o_phase_avg   = r_phase_avg;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_pps_phase_meter.sv
module tb_pps_phase_meter;

  localparam int CNT_W    = 24;
  localparam int AVG_LOG2 = 3;
  localparam int MAX_WIN  = 1000;
  localparam int TIMEOUT  = 2000;
  localparam int SAMPLE_N = 1 << AVG_LOG2;
  localparam int LAT      = 3;  // input raise to registered strobe, in clock edges

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic gps = 1'b0;
  logic loc = 1'b0;
  logic exist, pv, av, ovf;
  logic [CNT_W:0] val, avg;

  pps_phase_meter #(
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2),
    .MAX_WIN  (MAX_WIN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK_Sys       (clk),
    .CLK_Rst       (rst_n),
    .i_1PPS_GPS    (gps),
    .i_1PPS_Local  (loc),
    .o_GPS_Exist   (exist),
    .o_phase_valid (pv),
    .o_phase_val   (val),
    .o_avg_valid   (av),
    .o_phase_avg   (avg),
    .o_overflow    (ovf)
  );

  always #50 clk = ~clk;

  // Event recorder: cyc counts rising edges; outputs are sampled on the falling edge.
  int cyc = 0;
  int n_pv = 0, n_ovf = 0, n_av = 0;
  int pv_cyc = -1, ovf_cyc = -1, fall_cyc = -1, rise_cyc = -1;
  logic [CNT_W:0] last_pv = '0, last_av = '0;
  logic exist_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pv === 1'b1) begin
      n_pv    <= n_pv + 1;
      last_pv <= val;
      pv_cyc  <= cyc;
    end
    if (ovf === 1'b1) begin
      n_ovf   <= n_ovf + 1;
      ovf_cyc <= cyc;
    end
    if (av === 1'b1) begin
      n_av    <= n_av + 1;
      last_av <= avg;
    end
    if (exist_prev && !exist) fall_cyc <= cyc;
    if (!exist_prev && exist) rise_cyc <= cyc;
    exist_prev <= exist;
  end

  int checks = 0;
  int failures = 0;
  int q[$];            // accepted samples not yet averaged
  int last_gps_cyc = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint s);
    if (s >= 0) return s / SAMPLE_N;
    return -((-s + SAMPLE_N - 1) / SAMPLE_N);
  endfunction

  // d > 0: GPS rises, local d cycles later; d < 0: local first; d == 0: together.
  task automatic meas(input int d);
    int tg, tl, span, c_g, c_l, c_close, pv0, ov0, av0;
    longint s;
    int exp_av;
    longint exp_avg;
    tg = (d < 0) ? -d : 0;
    tl = (d > 0) ? d : 0;
    span = ((d < 0) ? -d : d) + 3;
    c_g = 0;
    c_l = 0;
    pv0 = n_pv;
    ov0 = n_ovf;
    av0 = n_av;
    for (int t = 0; t < span; t++) begin
      @(negedge clk);
      gps = (t >= tg && t < tg + 2);
      loc = (t >= tl && t < tl + 2);
      if (t == tg) c_g = cyc;
      if (t == tl) c_l = cyc;
    end
    @(negedge clk);
    gps = 1'b0;
    loc = 1'b0;
    repeat (8) @(negedge clk);
    last_gps_cyc = c_g;
    c_close = (c_g > c_l) ? c_g : c_l;
    q.push_back(d);
    exp_av = 0;
    exp_avg = 0;
    if (q.size() == SAMPLE_N) begin
      s = 0;
      foreach (q[i]) s += q[i];
      exp_avg = floor_div(s);
      exp_av = 1;
      q.delete();
    end
    chk($sformatf("pv_count d=%0d", d), n_pv - pv0, 1);
    chk($sformatf("pv_value d=%0d", d), $signed(last_pv), d);
    chk($sformatf("pv_time d=%0d", d), pv_cyc, c_close + LAT);
    chk($sformatf("no_ovf d=%0d", d), n_ovf - ov0, 0);
    chk($sformatf("avg_count d=%0d", d), n_av - av0, exp_av);
    if (exp_av != 0) chk($sformatf("avg_value d=%0d", d), $signed(last_av), exp_avg);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exist"}, exist, 0);
    chk({tag, "_pv"}, pv, 0);
    chk({tag, "_val"}, val, 0);
    chk({tag, "_av"}, av, 0);
    chk({tag, "_avg"}, avg, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int c, pv0, ov0;
    #20 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ramp 10..17 -> average 13
    for (int i = 10; i <= 17; i++) meas(i);
    chk("avg_ramp_13", $signed(last_av), 13);
    // Alternating -1/-2 -> floor(-1.5) = -2
    for (int i = 0; i < 8; i++) meas((i % 2 == 0) ? -1 : -2);
    chk("avg_floor_neg2", $signed(last_av), -2);

    meas(100);
    meas(-37);
    chk("neg37_raw", {39'd0, last_pv}, 64'h1FFFFDB);
    meas(0);
    meas(-MAX_WIN);
    meas(MAX_WIN);

    // GPS edge with no local edge -> overflow exactly MAX_WIN cycles after gps_p
    pv0 = n_pv;
    ov0 = n_ovf;
    @(negedge clk);
    gps = 1'b1;
    c = cyc;
    repeat (2) @(negedge clk);
    gps = 1'b0;
    repeat (MAX_WIN + 10) @(negedge clk);
    last_gps_cyc = c;
    chk("ovf_count", n_ovf - ov0, 1);
    chk("ovf_time", ovf_cyc, c + LAT + MAX_WIN);
    chk("ovf_no_pv", n_pv - pv0, 0);
    meas(100);

    for (int i = 0; i < 20; i++) meas(int'($urandom_range(0, 1600)) - 800);

    // GPS removal: leave a partial average behind, then let the timeout expire
    meas(5);
    while (q.size() == 0) meas(7);
    for (int i = 0; i < TIMEOUT + 100 && exist; i++) @(negedge clk);
    @(negedge clk);
    chk("exist_dropped", exist, 0);
    chk("exist_fall_time", fall_cyc, last_gps_cyc + LAT + TIMEOUT);
    q.delete();
    meas(20);
    chk("exist_rise_time", rise_cyc, last_gps_cyc + LAT);
    for (int i = 1; i <= 7; i++) meas(i);
    chk("avg_after_resume", $signed(last_av), 6);

    // Reset in the middle of WAIT_LOC
    @(negedge clk);
    gps = 1'b1;
    repeat (2) @(negedge clk);
    gps = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("midreset");
    pv0 = n_pv;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset_no_pv", n_pv - pv0, 0);
    q.delete();
    meas(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
